// File: rtl/comm_pkg.sv
// Shared definitions for the comm_send / comm_recv pair: word geometry, idle code,
// sample-pair payload and the word-to-pair extraction helper.
package comm_pkg;

    localparam int unsigned COMM_WORD_W   = 128;
    localparam int unsigned COMM_SAMPLE_W = 8;
    localparam int unsigned COMM_PAIRS    = 8;
    localparam int unsigned COMM_PIDX_W   = $clog2(COMM_PAIRS);
    localparam int unsigned COMM_PAIR_W   = 2 * COMM_SAMPLE_W;

    localparam logic [COMM_SAMPLE_W-1:0] COMM_IDLE_CODE = 8'h80;

    typedef logic [COMM_WORD_W-1:0] comm_word_t;

    // One DA sample pair; da2 occupies the upper byte of each 16-bit lane.
    typedef struct packed {
        logic [COMM_SAMPLE_W-1:0] da2;
        logic [COMM_SAMPLE_W-1:0] da1;
    } comm_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_STARVED = 2'd2
    } comm_send_state_t;

    function automatic comm_pair_t comm_pair(input comm_word_t word,
                                             input logic [COMM_PIDX_W-1:0] k);
        return comm_pair_t'(word[{k, 4'd0} +: COMM_PAIR_W]);
    endfunction

endpackage

// File: rtl/comm_send_if.sv
// FIFO read port plus dual DA sample outputs of comm_send.
interface comm_send_if;
    import comm_pkg::*;

    logic                     rd_en;
    logic [COMM_WORD_W-1:0]   din;
    logic                     empty;
    logic [COMM_SAMPLE_W-1:0] da1;
    logic [COMM_SAMPLE_W-1:0] da2;
    logic                     da_valid;
    logic                     underrun;

    modport master (
        output rd_en,
        input  din,
        input  empty,
        output da1,
        output da2,
        output da_valid,
        output underrun
    );

    modport slave (
        input  rd_en,
        output din,
        output empty,
        input  da1,
        input  da2,
        input  da_valid,
        input  underrun
    );

endinterface

// File: rtl/comm_tick_div.sv
// Sample-rate divider: tick is high for one cycle out of every DIV while en is high.
module comm_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/comm_send.sv
// Transmit side: prefetches 128-bit FIFO words and plays them out as eight
// (da1, da2) pairs, one per divider tick, with idle-code fallback on underrun.
module comm_send
    import comm_pkg::*;
#(
    parameter int unsigned              DIV       = 4,
    parameter logic [COMM_SAMPLE_W-1:0] IDLE_CODE = COMM_IDLE_CODE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    output logic        busy,
    comm_send_if.master bus
);

    localparam logic [COMM_PIDX_W-1:0] LAST_PAIR = COMM_PIDX_W'(COMM_PAIRS - 1);

    comm_send_state_t        state, state_n;
    comm_word_t              sreg, sreg_n;
    comm_word_t              nbuf, nbuf_n;
    logic [COMM_PIDX_W-1:0]  pidx, pidx_n;
    logic                    nvalid, nvalid_n;
    logic                    pending, pending_n;
    comm_pair_t              da, da_n;
    logic                    da_valid, da_valid_n;
    logic                    underrun, underrun_n;
    logic                    tick;
    logic                    rd_en;

    comm_tick_div #(.DIV(DIV)) u_div (
        .CLK  (CLK),
        .RST  (RST),
        .en   (en),
        .tick (tick)
    );

    // Single outstanding read, only into an empty prefetch buffer.
    assign rd_en    = !RST && !nvalid && !pending && !bus.empty;
    assign bus.rd_en    = rd_en;
    assign bus.da1      = da.da1;
    assign bus.da2      = da.da2;
    assign bus.da_valid = da_valid;
    assign bus.underrun = underrun;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            nbuf     <= '0;
            pidx     <= '0;
            nvalid   <= 1'b0;
            pending  <= 1'b0;
            da       <= '{da2: IDLE_CODE, da1: IDLE_CODE};
            da_valid <= 1'b0;
            underrun <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            nbuf     <= nbuf_n;
            pidx     <= pidx_n;
            nvalid   <= nvalid_n;
            pending  <= pending_n;
            da       <= da_n;
            da_valid <= da_valid_n;
            underrun <= underrun_n;
            busy     <= (state_n == ST_STREAM) || nvalid_n || pending_n;
        end
    end

    // ST_STARVED is "not active but started": the next empty tick reports underrun.
    always_comb begin
        state_n    = state;
        sreg_n     = sreg;
        nbuf_n     = nbuf;
        pidx_n     = pidx;
        nvalid_n   = nvalid;
        pending_n  = pending;
        da_n       = da;
        da_valid_n = 1'b0;
        underrun_n = 1'b0;

        if (pending) begin
            nbuf_n    = bus.din;
            nvalid_n  = 1'b1;
            pending_n = 1'b0;
        end
        if (rd_en) begin
            pending_n = 1'b1;
        end

        if (tick) begin
            unique case (state)
                ST_STREAM: begin
                    da_n       = comm_pair(sreg, pidx);
                    da_valid_n = 1'b1;
                    pidx_n     = pidx + COMM_PIDX_W'(1);
                    if (pidx == LAST_PAIR) begin
                        if (nvalid) begin
                            sreg_n   = nbuf;
                            nvalid_n = 1'b0;
                            pidx_n   = '0;
                        end else begin
                            state_n = ST_STARVED;
                        end
                    end
                end
                ST_IDLE, ST_STARVED: begin
                    if (nvalid) begin
                        sreg_n     = nbuf;
                        nvalid_n   = 1'b0;
                        da_n       = comm_pair(nbuf, COMM_PIDX_W'(0));
                        da_valid_n = 1'b1;
                        pidx_n     = COMM_PIDX_W'(1);
                        state_n    = ST_STREAM;
                    end else if (state == ST_STARVED) begin
                        da_n       = '{da2: IDLE_CODE, da1: IDLE_CODE};
                        underrun_n = 1'b1;
                        state_n    = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/comm_send.md
# comm_send

Transmit-side counterpart of `comm_recv`. Reads 128-bit words from the transmit FIFO and unpacks each word into eight (da1, da2) byte pairs. Presents one pair per sample tick to the dual 8-bit DA interface. Sample rate is set by a programmable clock divider; on FIFO underrun the outputs drop to a mid-scale idle code.

## Interface
- `DIV`, 4: sample period in `CLK` cycles; legal range 2..256.
- `IDLE_CODE`, 8'h80: value driven on `da1`/`da2` at reset and after underrun.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `en`  in  1  when high, the sample divider runs. When low, the divider is held at 0 and no pairs are emitted; FIFO prefetch continues.
- `rd_en`  out  1  FIFO read strobe, one cycle per word.
- `din`  in  128  FIFO read data, valid the cycle after `rd_en`.
- `empty`  in  1  FIFO empty flag.
- `da1`  out  8  channel-1 sample, registered; holds its value between ticks.
- `da2`  out  8  channel-2 sample, registered; holds its value between ticks.
- `da_valid`  out  1  one-cycle pulse when a new pair is presented on `da1`/`da2`.
- `underrun`  out  1  one-cycle pulse: a tick occurred while streaming but no data was available.
- `busy`  out  1  high while a word is active, a word is prefetched, or a read is pending.

## Operation
- Word layout: pair k (k = 0..7) is `da1 = din[16k+7:16k]`, `da2 = din[16k+15:16k+8]`. Pair 0 is emitted first. This is the same layout `comm_recv` packs.
- Storage:
  - shift register `sreg` (128 bits) plus 3-bit pair index `pidx` and `active` flag;
  - prefetch buffer `nbuf` (128 bits) plus `nvalid` flag;
  - `pending` flag for an outstanding read.
- Prefetch: `rd_en = !nvalid && !pending && !empty`, driven combinationally.
  - On the cycle `rd_en` is high, `pending` is set.
  - On the next edge, `din` is captured into `nbuf`, `nvalid` is set and `pending` is cleared.
  - Never more than one read is outstanding, and `rd_en` is never asserted while `empty` is high.
- Divider: counter 0..DIV-1 runs while `en` is high; a tick occurs when the counter equals DIV-1.
- On each tick, exactly one of the following applies:
  - `active`: emit pair `pidx` and increment `pidx`. If `pidx` was 7:
    - if `nvalid`, load `sreg` from `nbuf`, clear `nvalid`, set `pidx` = 0 and keep `active`;
    - otherwise clear `active`.
  - `!active && nvalid`: load `nbuf`, emit its pair 0 on this same tick, set `pidx` = 1, set `active`, clear `nvalid`, set `started`.
  - `!active && !nvalid && started`: drive `da1` = `da2` = `IDLE_CODE`, pulse `underrun`, clear `started`, keep `da_valid` = 0.
  - `!active && !nvalid && !started`: no action.
- A load into `nbuf` and a transfer out of `nbuf` in the same cycle cannot occur, because `rd_en` requires `!nvalid`.
- Reset mid-operation discards `sreg`, `nbuf` and any pending read; the FIFO word that was in flight is lost.

## Timing
- Reset values:
  - `da1` = `da2` = `IDLE_CODE`;
  - `da_valid` = `underrun` = 0;
  - `rd_en` = 0 while `RST` is high;
  - all flags and counters 0;
  - `busy` = 0.
- The emitted pair and `da_valid` appear on the registered outputs one cycle after the tick edge.
- `da_valid` spacing in steady state is exactly DIV cycles.
- Back-to-back words produce no gap, since the refetch (2 cycles) completes well inside the remaining 7 ticks.
- First-pair latency from `empty` falling, with the block idle and `en` high: at most DIV+2 cycles.
- `en` deasserted mid-word: pairs freeze and resume on the following ticks with no loss.

## Structure
- Shared package `comm_pkg` (also used by `comm_recv`) holds:
  - `COMM_WORD_W` = 128 and `COMM_SAMPLE_W` = 8;
  - `COMM_PAIRS` = 8;
  - the default `IDLE_CODE`;
  - the pair-extract function (word, k) -> {da2, da1}.
- One sub-module, `comm_tick_div` (parameter DIV; ports CLK, RST, en, tick), implements the divider.

## Test plan
- One word 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, DIV=4 -> exactly one `rd_en`, then 8 `da_valid` pulses 4 cycles apart giving (da1, da2) = (00,01), (02,03), …, (0E,0F). Then `underrun` pulses once and `da1` = `da2` = 80.
- Three words queued -> 24 pairs in order with uniform 4-cycle spacing, no `underrun`, and `rd_en` count = 3.
- `empty` held high for 100 cycles after reset -> `rd_en` stays 0, `da_valid` stays 0, `underrun` stays 0, and `busy` stays 0.
- `en` dropped for 10 cycles after pair 3 -> pairs 4..7 follow after re-enable with no pair lost or duplicated.
- `RST` asserted asynchronously mid-edge during pair 5 -> outputs return to the reset values immediately. After release, the next FIFO word starts at pair 0.
- DIV=2 with 4 queued words -> `da_valid` every 2 cycles for 32 pairs, no `underrun`.
